// File: rtl/switch_debouncer.sv
// Push-button debouncer: two-flop synchronizer feeding a four-state
// stability FSM. db_level is the clean button level; db_pulse is a single
// cycle strobe on each qualified press.
// Optional macro REPEAT_EN: while the button stays pressed, db_pulse repeats
// every REPEAT_MAX+1 cycles. Without it, only one pulse is issued per press.
module switch_debouncer #(
  parameter int CNT_W      = 26,
  parameter int STABLE_MAX = 999_999,
  parameter int REPEAT_MAX = 49_999_999
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_in,
  output logic db_level,
  output logic db_pulse
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_HI,
    HIGH,
    WAIT_LO
  } state_t;

  // The counter saturates at the larger of the two terminal counts.
  // It can therefore never wrap, even if CNT_W is wider than needed.
  localparam int               CNT_LIMIT = (STABLE_MAX > REPEAT_MAX) ? STABLE_MAX : REPEAT_MAX;
  localparam logic [CNT_W-1:0] STABLE_TC = CNT_W'(STABLE_MAX);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_LIMIT);
`ifdef REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_MAX);
`endif

  state_t           state;
  state_t           state_next;
  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] cnt_inc;
  logic             level_next;
  logic             pulse_next;

  assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;

  // Bring the asynchronous button level into the clk domain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= sw_in;
      s2 <= s1;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      db_level <= 1'b0;
      db_pulse <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      db_level <= level_next;
      db_pulse <= pulse_next;
    end
  end

  // Next-state logic. The counter defaults to zero, so it clears on every
  // state change and everywhere it is not explicitly advanced.
  always_comb begin
    state_next = state;
    cnt_next   = '0;
    level_next = db_level;
    pulse_next = 1'b0;
    case (state)
      IDLE: begin
        if (s2) state_next = WAIT_HI;
      end
      WAIT_HI: begin
        if (!s2) begin
          state_next = IDLE;
        end else if (cnt == STABLE_TC) begin
          state_next = HIGH;
          level_next = 1'b1;
          pulse_next = 1'b1;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      HIGH: begin
        if (!s2) begin
          state_next = WAIT_LO;
        end
`ifdef REPEAT_EN
        else if (cnt == REPEAT_TC) begin
          pulse_next = 1'b1;
        end else begin
          cnt_next = cnt_inc;
        end
`endif
      end
      WAIT_LO: begin
        if (s2) begin
          state_next = HIGH;
        end else if (cnt == STABLE_TC) begin
          state_next = IDLE;
          level_next = 1'b0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
